// File: rtl/race_pkg.sv
// Shared definitions for the race tracker slice: phase encoding, default timing
// constants and the packed-bus index helper.
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RACING = 2'd1,
    ST_DONE   = 2'd2
  } race_state_e;

  localparam int unsigned FINISH_POS_DEFAULT = 100000;
  localparam int unsigned TICK_DIV_100HZ     = 1000000;

  // Low bit of field idx in a bus of equal-width fields.
  function automatic int unsigned pack_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/race_position_tracker_if.sv
// Player data and race status bus between speed logic and the tracker.
// RACE_FALSE_START_EN adds the per-player disqualified flags.
interface race_position_tracker_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned POS_W       = 32,
  parameter int unsigned DPOS_W      = 5
);
  logic                          reset_status;
  logic                          race_go;
  logic [NUM_PLAYERS*DPOS_W-1:0] d_position;
  logic [NUM_PLAYERS*POS_W-1:0]  position;
  logic [NUM_PLAYERS-1:0]        finished;
  logic [2:0]                    winner;
  logic                          winner_valid;
  logic                          tie;
  logic                          racing;
  logic                          tick;
`ifdef RACE_FALSE_START_EN
  logic [NUM_PLAYERS-1:0]        disqualified;

  modport master (
    output reset_status, race_go, d_position,
    input  position, finished, winner, winner_valid, tie, racing, tick, disqualified
  );
  modport slave (
    input  reset_status, race_go, d_position,
    output position, finished, winner, winner_valid, tie, racing, tick, disqualified
  );
`else
  modport master (
    output reset_status, race_go, d_position,
    input  position, finished, winner, winner_valid, tie, racing, tick
  );
  modport slave (
    input  reset_status, race_go, d_position,
    output position, finished, winner, winner_valid, tie, racing, tick
  );
`endif
endinterface

// File: rtl/race_position_tracker_tick_gen.sv
// Free-running 0..TICK_DIV-1 counter; tick is high for the cycle at TICK_DIV-1.
// Used as a clock enable in place of a divided clock.
module tick_gen
  import race_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_100HZ
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    tick    = (count_q == CNT_W'(TICK_DIV - 1));
    count_d = tick ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/race_position_tracker.sv
// Multi-player position tracker with finish saturation, race phase FSM and
// winner/tie arbitration. RACE_FALSE_START_EN enables false-start disqualification.
module race_position_tracker
  import race_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned TICK_DIV    = TICK_DIV_100HZ,
  parameter int unsigned POS_W       = 32,
  parameter int unsigned DPOS_W      = 5,
  parameter int unsigned FINISH_POS  = FINISH_POS_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  race_position_tracker_if.slave bus
);
  localparam logic [POS_W:0]   FIN_EXT = (POS_W+1)'(FINISH_POS);
  localparam logic [POS_W-1:0] FIN_POS = POS_W'(FINISH_POS);

  logic tick;

  race_state_e            state_q, state_d;
  logic [POS_W-1:0]       pos_q [NUM_PLAYERS];
  logic [POS_W-1:0]       pos_d [NUM_PLAYERS];
  logic [POS_W:0]         sum   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] fin_q, fin_d, new_fin, out_q, out_d;
  logic [2:0]             winner_q, winner_d;
  logic                   wv_q, wv_d, tie_q, tie_d, racing_q, racing_d;
`ifdef RACE_FALSE_START_EN
  logic [NUM_PLAYERS-1:0] dq_q, dq_d;
`endif

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // One bit of headroom so a near-finish increment cannot wrap past FINISH_POS.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      sum[i] = (POS_W+1)'(pos_q[i])
             + (POS_W+1)'(bus.d_position[pack_lo(i, DPOS_W) +: DPOS_W]);
    end
  end

  // out_q marks players that take no further part: finished or disqualified.
  always_comb begin
`ifdef RACE_FALSE_START_EN
    out_q = fin_q | dq_q;
`else
    out_q = fin_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    fin_d    = fin_q;
    winner_d = winner_q;
    wv_d     = wv_q;
    tie_d    = tie_q;
    new_fin  = '0;
    out_d    = out_q;
`ifdef RACE_FALSE_START_EN
    dq_d     = dq_q;
`endif
    if (bus.reset_status) begin
      state_d  = ST_IDLE;
      pos_d    = '{default: '0};
      fin_d    = '0;
      winner_d = '0;
      wv_d     = 1'b0;
      tie_d    = 1'b0;
`ifdef RACE_FALSE_START_EN
      dq_d     = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef RACE_FALSE_START_EN
          for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (bus.d_position[pack_lo(i, DPOS_W) +: DPOS_W] != '0) dq_d[i] = 1'b1;
          end
          if (bus.race_go) state_d = (&dq_d) ? ST_DONE : ST_RACING;
`else
          if (bus.race_go) state_d = ST_RACING;
`endif
        end
        ST_RACING: begin
          if (tick) begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
              if (!out_q[i]) begin
                if (sum[i] >= FIN_EXT) begin
                  pos_d[i]   = FIN_POS;
                  new_fin[i] = 1'b1;
                end else begin
                  pos_d[i] = sum[i][POS_W-1:0];
                end
              end
            end
            fin_d = fin_q | new_fin;
            out_d = out_q | new_fin;
            if (!wv_q && (new_fin != '0)) begin
              wv_d  = 1'b1;
              tie_d = (new_fin & (new_fin - NUM_PLAYERS'(1))) != '0;
              // Scanning from the top leaves the lowest new finisher last.
              for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                if (new_fin[NUM_PLAYERS-1-i]) winner_d = 3'(NUM_PLAYERS - 1 - i);
              end
            end
            if (&out_d) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
    racing_d = (state_d == ST_RACING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_q    <= '{default: '0};
      fin_q    <= '0;
      winner_q <= '0;
      wv_q     <= 1'b0;
      tie_q    <= 1'b0;
      racing_q <= 1'b0;
`ifdef RACE_FALSE_START_EN
      dq_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      fin_q    <= fin_d;
      winner_q <= winner_d;
      wv_q     <= wv_d;
      tie_q    <= tie_d;
      racing_q <= racing_d;
`ifdef RACE_FALSE_START_EN
      dq_q     <= dq_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pos
    assign bus.position[pack_lo(g, POS_W) +: POS_W] = pos_q[g];
  end

  assign bus.finished     = fin_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = wv_q;
  assign bus.tie          = tie_q;
  assign bus.racing       = racing_q;
  assign bus.tick         = tick;
`ifdef RACE_FALSE_START_EN
  assign bus.disqualified = dq_q;
`endif

endmodule
